// File: rtl/sjr_block.sv
// sjr_block: board demo top. It runs a cycle counter and LED mirror on clk,
// fills an RGB332 character-cell frame buffer, and scans it out as 640x480 VGA on clkv.
// It also makes a switch-tuned square-wave tone on clka.
// Ports:
//   clk/reset    : system domain, with hexLED/redLED out and boardSW/boardKey in.
//   vram_ext_*   : video clock/reset in; hs, vs, de and rgb out.
//   psg_audio_*  : audio clock/reset in; left/right tone out.
module sjr_block #(
   parameter int CELL_W = 80,
   parameter int CELL_H = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vram_ext_clkv_exp,
   input  logic        vram_ext_resetv_exp,
   output logic        vram_ext_vga_hs_exp,
   output logic        vram_ext_vga_vs_exp,
   output logic        vram_ext_vga_de_exp,
   output logic [7:0]  vram_ext_vga_r_exp,
   output logic [7:0]  vram_ext_vga_g_exp,
   output logic [7:0]  vram_ext_vga_b_exp,
   input  logic        psg_audio_ext_clka_exp,
   input  logic        psg_audio_ext_reseta_exp,
   output logic        psg_audio_ext_audio_r_exp,
   output logic        psg_audio_ext_audio_l_exp,
   output logic [31:0] hexLED_ext_hex_led_exp,
   output logic [15:0] redLED_ext_red_led_exp,
   input  logic [15:0] boardSW_ext_board_switch_exp,
   input  logic [7:0]  boardKey_ext_board_key_exp
);

   localparam int DEPTH = CELL_W * CELL_H;
   localparam int AW    = $clog2(DEPTH);

   // ---------------- system domain ----------------
   logic [31:0]   cnt_q;
   logic [31:0]   hex_q;
   logic [15:0]   red_q;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [7:0]    frame_q, frame_d;
   logic [7:0]    wdata;

   always_comb begin
      waddr_d = waddr_q + AW'(1);
      frame_d = frame_q;
      if (waddr_q == AW'(DEPTH - 1)) begin
         waddr_d = '0;
         frame_d = frame_q + 8'd1;
      end
   end

   assign wdata = waddr_q[7:0] + frame_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         hex_q   <= '0;
         red_q   <= '0;
         waddr_q <= '0;
         frame_q <= '0;
      end else begin
         cnt_q   <= cnt_q + 32'd1;
         hex_q   <= cnt_q;
         red_q   <= boardSW_ext_board_switch_exp
                    ^ {8'h00, boardKey_ext_board_key_exp};
         waddr_q <= waddr_d;
         frame_q <= frame_d;
      end
   end

   assign hexLED_ext_hex_led_exp = hex_q;
   assign redLED_ext_red_led_exp = red_q;

   // ---------------- frame buffer ----------------
   // Writes stop while the system is in reset, so the picture freezes.
   logic [7:0]    mem [DEPTH];
   logic [7:0]    rdata_q;
   logic [AW-1:0] raddr;

   always_ff @(posedge clk) begin
      if (!reset) mem[waddr_q] <= wdata;
   end

   always_ff @(posedge vram_ext_clkv_exp) begin
      rdata_q <= mem[raddr];
   end

   // ---------------- video domain ----------------
   logic [9:0] h_q, h_d, v_q, v_d;
   logic       vis, hs_n, vs_n;
   logic       vis1_q, hs1_q, vs1_q;
   logic       hs_q, vs_q, de_q;
   logic [7:0] r_q, g_q, b_q;
   logic [7:0] r_d, g_d, b_d;

   always_comb begin
      h_d = h_q + 10'd1;
      v_d = v_q;
      if (h_q == 10'd799) begin
         h_d = '0;
         v_d = (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      end
   end

   assign vis  = (h_q < 10'd640) && (v_q < 10'd480);
   assign hs_n = !((h_q >= 10'd656) && (h_q <= 10'd751));
   assign vs_n = !((v_q >= 10'd490) && (v_q <= 10'd491));

   // Blanking positions would index past the buffer, so park them at 0.
   assign raddr = vis ? AW'(v_q[9:3]) * AW'(CELL_W) + AW'(h_q[9:3])
                      : '0;

   // RGB332 expanded by bit replication.
   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if (vis1_q) begin
         r_d = {rdata_q[7:5], rdata_q[7:5], rdata_q[7:6]};
         g_d = {rdata_q[4:2], rdata_q[4:2], rdata_q[4:3]};
         b_d = {4{rdata_q[1:0]}};
      end
   end

   always_ff @(posedge vram_ext_clkv_exp) begin
      if (vram_ext_resetv_exp) begin
         h_q    <= '0;
         v_q    <= '0;
         vis1_q <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         de_q   <= 1'b0;
         r_q    <= '0;
         g_q    <= '0;
         b_q    <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         // stage 1 lines up with the RAM read
         vis1_q <= vis;
         hs1_q  <= hs_n;
         vs1_q  <= vs_n;
         // stage 2 registers all outputs
         hs_q   <= hs1_q;
         vs_q   <= vs1_q;
         de_q   <= vis1_q;
         r_q    <= r_d;
         g_q    <= g_d;
         b_q    <= b_d;
      end
   end

   assign vram_ext_vga_hs_exp = hs_q;
   assign vram_ext_vga_vs_exp = vs_q;
   assign vram_ext_vga_de_exp = de_q;
   assign vram_ext_vga_r_exp  = r_q;
   assign vram_ext_vga_g_exp  = g_q;
   assign vram_ext_vga_b_exp  = b_q;

   // ---------------- audio domain ----------------
   logic [7:0]  sw_m_q, sw_s_q;
   logic        key_m_q, key_s_q;
   logic [14:0] half_n;
   logic [14:0] acnt_q, acnt_d;
   logic        tone_q, tone_d;

   always_ff @(posedge psg_audio_ext_clka_exp) begin
      sw_m_q  <= boardSW_ext_board_switch_exp[7:0];
      sw_s_q  <= sw_m_q;
      key_m_q <= boardKey_ext_board_key_exp[0];
      key_s_q <= key_m_q;
   end

   assign half_n = {1'b0, sw_s_q, 6'd0} + 15'd64;

   // ">=" lets a shorter period take effect at once, even if the count is past it.
   always_comb begin
      acnt_d = acnt_q + 15'd1;
      tone_d = tone_q;
      if (acnt_q >= half_n - 15'd1) begin
         acnt_d = '0;
         tone_d = ~tone_q;
      end
   end

   always_ff @(posedge psg_audio_ext_clka_exp) begin
      if (psg_audio_ext_reseta_exp) begin
         acnt_q <= '0;
         tone_q <= 1'b0;
      end else begin
         acnt_q <= acnt_d;
         tone_q <= tone_d;
      end
   end

   assign psg_audio_ext_audio_l_exp = tone_q & ~key_s_q;
   assign psg_audio_ext_audio_r_exp = tone_q & ~key_s_q;

endmodule

// File: tb/tb_sjr_block.sv
// tb_sjr_block: self-checking bench for sjr_block.
// It uses randomized LED/audio stimulus and a behavioural VGA/tone model.
module tb_sjr_block;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clkv = 1'b0;
   logic        resetv = 1'b1;
   logic        clka = 1'b0;
   logic        reseta = 1'b1;
   logic        hs, vs, de;
   logic [7:0]  r, g, b;
   logic        aud_r, aud_l;
   logic [31:0] hex;
   logic [15:0] red;
   logic [15:0] sw = '0;
   logic [7:0]  key = '0;

   int checks = 0;
   int errors = 0;

   sjr_block dut (
      .clk                          (clk),
      .reset                        (reset),
      .vram_ext_clkv_exp            (clkv),
      .vram_ext_resetv_exp          (resetv),
      .vram_ext_vga_hs_exp          (hs),
      .vram_ext_vga_vs_exp          (vs),
      .vram_ext_vga_de_exp          (de),
      .vram_ext_vga_r_exp           (r),
      .vram_ext_vga_g_exp           (g),
      .vram_ext_vga_b_exp           (b),
      .psg_audio_ext_clka_exp       (clka),
      .psg_audio_ext_reseta_exp     (reseta),
      .psg_audio_ext_audio_r_exp    (aud_r),
      .psg_audio_ext_audio_l_exp    (aud_l),
      .hexLED_ext_hex_led_exp       (hex),
      .redLED_ext_red_led_exp       (red),
      .boardSW_ext_board_switch_exp (sw),
      .boardKey_ext_board_key_exp   (key)
   );

   always #10 clk = ~clk;
   initial begin
      #3;
      forever #20 clkv = ~clkv;
   end
   always #15 clka = ~clka;

   // Expected {hs, vs, de, r, g, b} after c clkv edges past video reset release.
   function automatic logic [26:0] vid_exp(input int c);
      int p, h, v, d, r3, g3, b2;
      logic vis, hx, vx;
      logic [7:0] er, eg, eb;
      if (c < 2) return {3'b110, 24'h0};
      p   = c - 2;
      h   = p % 800;
      v   = (p / 800) % 525;
      vis = (h < 640) && (v < 480);
      hx  = !(h >= 656 && h < 752);
      vx  = !(v >= 490 && v < 492);
      d   = ((v / 8) * 80 + (h / 8)) % 256;
      r3  = d / 32;
      g3  = (d / 4) % 8;
      b2  = d % 4;
      er  = 8'(r3 * 32 + r3 * 4 + r3 / 2);
      eg  = 8'(g3 * 32 + g3 * 4 + g3 / 2);
      eb  = 8'(b2 * 85);
      if (!vis) begin
         er = '0;
         eg = '0;
         eb = '0;
      end
      return {hx, vx, vis, er, eg, eb};
   endfunction

   // Square-wave level j cycles after a fresh start with half-period n.
   function automatic logic tone_at(input int j, input int n);
      return ((j / n) % 2) == 1;
   endfunction

   task automatic test_reset();
      sw  = 16'($urandom);
      key = 8'($urandom);
      repeat (4) @(posedge clk);
      repeat (4) @(posedge clkv);
      repeat (4) @(posedge clka);
      #1;
      checks++;
      if ({hex, red} !== 48'h0) begin
         errors++;
         $display("FAIL reset_sys got hex=%h red=%h exp 0/0", hex, red);
      end
      checks++;
      if ({hs, vs, de, r, g, b} !== {3'b110, 24'h0}) begin
         errors++;
         $display("FAIL reset_vid got %b%b%b %h%h%h exp 110 000000",
                  hs, vs, de, r, g, b);
      end
      checks++;
      if ({aud_l, aud_r} !== 2'b00) begin
         errors++;
         $display("FAIL reset_aud got %b%b exp 00", aud_l, aud_r);
      end
   endtask

   task automatic test_counters();
      @(posedge clk);
      #1;
      sw    = '0;
      key   = '0;
      reset = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (hex !== 32'(k - 1) || red !== 16'h0) begin
            errors++;
            $display("FAIL counter k=%0d got hex=%0d red=%h exp %0d/0",
                     k, hex, red, k - 1);
         end
      end
   endtask

   task automatic test_led_mirror();
      logic [15:0] e;
      for (int i = 0; i < 24; i++) begin
         if (i == 0) begin
            sw  = 16'h00F0;
            key = 8'h0F;
         end else begin
            sw  = 16'($urandom);
            key = 8'($urandom);
         end
         e = sw ^ {8'h00, key};
         @(posedge clk);
         #1;
         checks++;
         if (red !== e) begin
            errors++;
            $display("FAIL led_mirror i=%0d got %h exp %h", i, red, e);
         end
      end
      sw  = '0;
      key = '0;
   endtask

   // One full pass of writes from address 0, then freeze the buffer in reset.
   task automatic test_frame_fill();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (4800) @(posedge clk);
      #1;
      checks++;
      if (hex !== 32'd4799) begin
         errors++;
         $display("FAIL fill_hex got %0d exp 4799", hex);
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_video();
      int ncyc;
      int hs_lo;
      int de_hi;
      logic [26:0] e;
      ncyc  = 800 * 20 + 2;
      hs_lo = 0;
      de_hi = 0;
      @(posedge clkv);
      #1 resetv = 1'b1;
      repeat (3) @(posedge clkv);
      #1 resetv = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clkv);
         #1;
         e = vid_exp(c);
         checks++;
         if ({hs, vs, de, r, g, b} !== e) begin
            errors++;
            $display("FAIL video c=%0d got %b%b%b %h%h%h exp %b %h",
                     c, hs, vs, de, r, g, b, e[26:24], e[23:0]);
         end
         if (c >= 2 && c < 802) begin
            if (!hs) hs_lo++;
            if (de) de_hi++;
         end
         if (c == 2) begin
            checks++;
            if (!(de === 1'b1 && {r, g, b} === 24'h0)) begin
               errors++;
               $display("FAIL pix00 got de=%b rgb=%h exp 1/000000",
                        de, {r, g, b});
            end
         end
         if (c == 10) begin
            checks++;
            if ({r, g, b} !== 24'h000055) begin
               errors++;
               $display("FAIL pix80 got rgb=%h exp 000055", {r, g, b});
            end
         end
      end
      checks++;
      if (hs_lo != 96 || de_hi != 640) begin
         errors++;
         $display("FAIL line0 got hs_lo=%0d de_hi=%0d exp 96/640",
                  hs_lo, de_hi);
      end
   endtask

   // Restart the tone generator with switches s and check ncyc cycles.
   task automatic audio_run(input logic [7:0] s, input int ncyc);
      int n;
      logic e;
      n = int'(s) * 64 + 64;
      @(posedge clka);
      #1;
      sw     = {8'($urandom), s};
      key    = '0;
      reseta = 1'b1;
      repeat (4) @(posedge clka);
      #1 reseta = 1'b0;
      for (int j = 1; j <= ncyc; j++) begin
         @(posedge clka);
         #1;
         e = tone_at(j, n);
         checks++;
         if (aud_l !== e || aud_r !== e) begin
            errors++;
            $display("FAIL pitch s=%0d j=%0d got %b%b exp %b",
                     s, j, aud_l, aud_r, e);
         end
      end
   endtask

   task automatic test_audio_pitch();
      audio_run(8'd0, 4 * 64 + 10);
      audio_run(8'd1, 4 * 128 + 10);
      audio_run(8'($urandom_range(5, 2)), 1600);
   endtask

   task automatic test_mute();
      logic e;
      @(posedge clka);
      #1;
      sw     = '0;
      key    = '0;
      reseta = 1'b1;
      repeat (4) @(posedge clka);
      #1 reseta = 1'b0;
      for (int j = 1; j <= 300; j++) begin
         @(posedge clka);
         #1;
         if (j == 100) key = 8'($urandom) | 8'h01;
         if (j == 140) key = 8'($urandom) & 8'hFE;
         e = tone_at(j, 64);
         if (j >= 103 && j <= 140) e = 1'b0;
         if (!((j > 100 && j < 103) || (j > 140 && j < 143))) begin
            checks++;
            if (aud_l !== e || aud_r !== e) begin
               errors++;
               $display("FAIL mute j=%0d got %b%b exp %b",
                        j, aud_l, aud_r, e);
            end
         end
      end
      key = '0;
   endtask

   task automatic test_mid_reset();
      int n;
      int s;
      logic e;
      s = int'($urandom_range(2, 0));
      n = s * 64 + 64;
      @(posedge clka);
      #1;
      sw     = 16'(s);
      key    = '0;
      reseta = 1'b1;
      repeat (4) @(posedge clka);
      #1 reseta = 1'b0;
      repeat (n + n / 2) @(posedge clka);
      #1;
      checks++;
      if (aud_l !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre got %b exp 1", aud_l);
      end
      reseta = 1'b1;
      @(posedge clka);
      #1;
      checks++;
      if ({aud_l, aud_r} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_off got %b%b exp 00", aud_l, aud_r);
      end
      repeat (2) @(posedge clka);
      #1 reseta = 1'b0;
      for (int j = 1; j <= 2 * n + 5; j++) begin
         @(posedge clka);
         #1;
         e = tone_at(j, n);
         checks++;
         if (aud_l !== e || aud_r !== e) begin
            errors++;
            $display("FAIL midrst j=%0d got %b%b exp %b",
                     j, aud_l, aud_r, e);
         end
      end
   endtask

   // Shorten N while the count is already past the new end.
   // After two synchroniser stages the tone flips at once, then runs at the new period.
   task automatic test_retune();
      logic e;
      @(posedge clka);
      #1;
      sw     = 16'd3;
      key    = '0;
      reseta = 1'b1;
      repeat (4) @(posedge clka);
      #1 reseta = 1'b0;
      repeat (200) @(posedge clka);
      #1 sw = 16'd1;
      for (int j = 201; j <= 560; j++) begin
         @(posedge clka);
         #1;
         if (j < 203) e = 1'b0;
         else e = !tone_at(j - 203, 128);
         checks++;
         if (aud_l !== e || aud_r !== e) begin
            errors++;
            $display("FAIL retune j=%0d got %b%b exp %b",
                     j, aud_l, aud_r, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_counters();
      test_led_mirror();
      test_frame_fill();
      test_video();
      test_audio_pitch();
      test_mute();
      test_mid_reset();
      test_retune();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
